// File: rtl/xvc_pkg.sv
// Shared definitions for the XVC JTAG shift engine: default widths,
// the FSM state encoding and small helpers used by the datapath.
package xvc_pkg;

    localparam int XVC_WORD_W = 32;
    localparam int XVC_LEN_W  = 32;
    localparam int XVC_DIV_W  = 8;

    // Engine states; the encoding is fixed so waveforms stay readable.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LOW  = 3'd2,
        ST_HIGH = 3'd3,
        ST_EMIT = 3'd4
    } xvc_state_e;

    // True when the state is one of the two TCK phases.
    function automatic logic xvc_in_phase(input xvc_state_e state);
        logic result;
        case (state)
            ST_LOW:  result = 1'b1;
            ST_HIGH: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/xvc_tck_divider.sv
// Half-period counter for TCK. A load pulse restarts the phase with the
// programmed divider; phase_done is high on the last clock of the phase,
// so each phase lasts exactly div+1 clocks.
module xvc_tck_divider
    import xvc_pkg::*;
#(
    parameter int DIV_W = XVC_DIV_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_phase_done
);

    logic [DIV_W-1:0] r_count;

    // Down-counter: reload on phase start, count to zero and park there.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_div;
        end else if (r_count != '0) begin
            r_count <= r_count - {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_phase_done = (r_count == '0);

endmodule

// File: rtl/xvc_shift_engine.sv
// XVC shift engine: takes a (length, divider) command, pulls TMS/TDI words
// LSB first, clocks them out on the JTAG pins with a programmable TCK rate
// and returns the captured TDO bits as words. Word boundaries and stalls
// always happen with TCK low so the target never sees a stretched high phase.
module xvc_shift_engine
    import xvc_pkg::*;
#(
    parameter int WORD_W = XVC_WORD_W,
    parameter int LEN_W  = XVC_LEN_W,
    parameter int DIV_W  = XVC_DIV_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_tms,
    input  logic [WORD_W-1:0] in_tdi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_tdo,
    output logic              busy,
    output logic              jtag_tck,
    output logic              jtag_tms,
    output logic              jtag_tdi,
    input  logic              jtag_tdo
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    xvc_state_e        r_state;
    xvc_state_e        w_next_state;
    logic [LEN_W-1:0]  r_remaining;
    logic [DIV_W-1:0]  r_div;
    logic [WORD_W-1:0] r_tms_sh;
    logic [WORD_W-1:0] r_tdi_sh;
    logic [WORD_W-1:0] r_tdo;
    logic [IDX_W-1:0]  r_index;
    logic              r_tck;

    logic w_phase_done;
    logic w_div_load;
    logic w_cmd_fire;
    logic w_in_fire;
    logic w_out_fire;
    logic w_low_done;
    logic w_high_done;
    logic w_word_end;
    logic w_last_bit;
    logic w_emit_next;

    // Handshakes and phase events; ready/valid are decoded from the state
    // register only, which keeps them mutually exclusive by construction.
    assign cmd_ready   = (r_state == ST_IDLE);
    assign in_ready    = (r_state == ST_LOAD);
    assign out_valid   = (r_state == ST_EMIT);
    assign busy        = (r_state != ST_IDLE);
    assign w_cmd_fire  = cmd_ready & cmd_valid;
    assign w_in_fire   = in_ready & in_valid;
    assign w_out_fire  = out_valid & out_ready;
    assign w_low_done  = (r_state == ST_LOW) & w_phase_done;
    assign w_high_done = (r_state == ST_HIGH) & w_phase_done;
    assign w_word_end  = (r_index == LAST_IDX);
    assign w_last_bit  = (r_remaining == LEN_W'(1));
    assign w_emit_next = w_word_end | w_last_bit;

    // The divider restarts at the start of every LOW and HIGH phase.
    assign w_div_load = w_in_fire | (xvc_in_phase(r_state) & w_phase_done);

    xvc_tck_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_div_load),
        .i_div        (r_div),
        .o_phase_done (w_phase_done)
    );

    // Next-state decode for the command / word / bit sequencing.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire && (cmd_len != '0)) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    w_next_state = ST_LOW;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOW: begin
                if (w_phase_done) begin
                    w_next_state = ST_HIGH;
                end else begin
                    w_next_state = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (w_phase_done && w_emit_next) begin
                    w_next_state = ST_EMIT;
                end else if (w_phase_done) begin
                    w_next_state = ST_LOW;
                end else begin
                    w_next_state = ST_HIGH;
                end
            end
            ST_EMIT: begin
                if (out_ready && (r_remaining == '0)) begin
                    w_next_state = ST_IDLE;
                end else if (out_ready) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_EMIT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command parameters: latched on acceptance, remaining bits count down
    // once per completed TCK cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div       <= '0;
            r_remaining <= '0;
        end else if (w_cmd_fire) begin
            r_div       <= cmd_div;
            r_remaining <= cmd_len;
        end else if (w_high_done) begin
            r_div       <= r_div;
            r_remaining <= r_remaining - LEN_W'(1);
        end else begin
            r_div       <= r_div;
            r_remaining <= r_remaining;
        end
    end

    // TMS/TDI shift registers; bit 0 drives the pins. No shift after the
    // final bit of a word or command, so the pins hold the last value
    // through EMIT, LOAD stalls and IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tms_sh <= '1;
            r_tdi_sh <= '0;
        end else if (w_in_fire) begin
            r_tms_sh <= in_tms;
            r_tdi_sh <= in_tdi;
        end else if (w_high_done && !w_emit_next) begin
            r_tms_sh <= {1'b0, r_tms_sh[WORD_W-1:1]};
            r_tdi_sh <= {1'b0, r_tdi_sh[WORD_W-1:1]};
        end else begin
            r_tms_sh <= r_tms_sh;
            r_tdi_sh <= r_tdi_sh;
        end
    end

    // TDO capture and bit index; TDO is sampled on the last HIGH clock,
    // and the cleared register leaves untouched upper bits at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tdo   <= '0;
            r_index <= '0;
        end else if (w_in_fire) begin
            r_tdo   <= '0;
            r_index <= '0;
        end else if (w_high_done) begin
            r_tdo[r_index] <= jtag_tdo;
            if (w_emit_next) begin
                r_index <= r_index;
            end else begin
                r_index <= r_index + IDX_W'(1);
            end
        end else begin
            r_tdo   <= r_tdo;
            r_index <= r_index;
        end
    end

    // TCK: rises entering HIGH, falls leaving it; low everywhere else.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tck <= 1'b0;
        end else if (w_low_done) begin
            r_tck <= 1'b1;
        end else if (w_high_done) begin
            r_tck <= 1'b0;
        end else if (xvc_in_phase(r_state)) begin
            r_tck <= r_tck;
        end else begin
            r_tck <= 1'b0;
        end
    end

    assign jtag_tck = r_tck;
    assign jtag_tms = r_tms_sh[0];
    assign jtag_tdi = r_tdi_sh[0];
    assign out_tdo  = r_tdo;

endmodule

// File: doc/xvc_shift_engine.md
XVC_SHIFT_ENGINE -- requirements
Module: xvc_shift_engine

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- WORD_W, 32, width of TMS/TDI/TDO stream words.
- LEN_W, 32, width of the shift bit-count.
- DIV_W, 8, width of the TCK half-period divider.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clock in 1: single clock; all logic on its rising edge.
- reset in 1: asynchronous, active-high.
- cmd_valid in 1; cmd_ready out 1: command handshake.
- cmd_len in LEN_W: number of TCK cycles (bits) to shift.
- cmd_div in DIV_W: TCK half-period in clocks, minus 1.
- in_valid in 1; in_ready out 1: input word handshake.
- in_tms in WORD_W; in_tdi in WORD_W: TMS and TDI bits, LSB first.
- out_valid out 1; out_ready in 1; out_tdo out WORD_W: captured TDO word, LSB first.
- busy out 1: command in progress.
- jtag_tck out 1; jtag_tms out 1; jtag_tdi out 1; jtag_tdo in 1: JTAG pins.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, LOW, HIGH and EMIT; cmd_ready=1 and busy=0 only in IDLE.
REQ-004 On the IDLE cmd handshake, the block SHALL latch cmd_len and cmd_div; cmd_len=0 SHALL return to IDLE next cycle, consuming and producing no words.
REQ-005 LOAD SHALL assert in_ready and, on handshake, latch in_tms/in_tdi into shift registers, clear the TDO register and the bit index, then enter LOW.
REQ-006 On entry to LOW, jtag_tck SHALL be 0 and jtag_tms/jtag_tdi SHALL present the current bit; LOW SHALL last cmd_div+1 clocks.
REQ-007 HIGH SHALL drive jtag_tck=1 for cmd_div+1 clocks and sample jtag_tdo into TDO bit [index] on the last HIGH clock.
REQ-008 The TCK period SHALL be 2*(cmd_div+1) clocks; cmd_div=0 SHALL yield clock/2.
REQ-009 After HIGH, the block SHALL decrement remaining bits and go to EMIT if the word is complete (index=WORD_W-1) or remaining=0; otherwise it SHALL return to LOW with index+1.
REQ-010 EMIT SHALL assert out_valid with out_tdo held stable; unshifted upper bits of a final partial word SHALL be 0.
REQ-011 On the out handshake, EMIT SHALL go to IDLE if remaining=0, else to LOAD.
REQ-012 Backpressure (in_valid=0 in LOAD, out_ready=0 in EMIT) SHALL stall with jtag_tck=0 and jtag_tms/jtag_tdi held.
REQ-013 A command SHALL consume and produce exactly ceil(cmd_len/WORD_W) words; an exact multiple SHALL produce no extra word.
REQ-014 Between commands, jtag_tms and jtag_tdi SHALL hold the last shifted values; jtag_tck SHALL be 0.
REQ-015 cmd_ready, in_ready and out_valid SHALL be mutually exclusive.

Reset
REQ-016 Reset SHALL immediately force state=IDLE, jtag_tck=0, jtag_tms=1, jtag_tdi=0, out_valid=0, in_ready=0, busy=0, out_tdo=0 and counters=0.
REQ-017 Reset mid-command SHALL abort it; no partial word SHALL be emitted after release.
REQ-018 After release, cmd_ready SHALL be 1 on the first clock.

Structure
REQ-019 Package xvc_pkg SHALL hold the state enum and the WORD_W/LEN_W/DIV_W defaults.
REQ-020 Sub-module xvc_tck_divider SHALL hold the half-period counter, taking load and div and giving a phase_done pulse.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- len=8, div=0, tms=0x00, tdi=0xA5, tdo looped from tdi: one out word 0x000000A5; 8 TCK pulses of period 2 clocks.
- len=64, div=3, tdi=0xDEADBEEF and 0x12345678 looped: two words, same values; TCK period 8 clocks.
- len=0: cmd_ready back to 1 after 1 cycle; no in/out handshakes; no TCK edges.
- len=5, tdo tied 1: out_tdo=0x0000001F.
- out_ready held 0 for 20 cycles after the first word of len=40: jtag_tck stays 0 throughout; no bit lost on resume.
- reset asserted during HIGH of bit 3: jtag_tck=0 and jtag_tms=1 within the same cycle; no out_valid after release.
